// File: rtl/ncpu32k_sram_arbiter.sv
// ncpu32k_sram_arbiter
//   Lets the instruction bus (i_*) and the data bus (d_*) of one ncpu32k core
//   share a single command/response SRAM slave (s_*). Only one transaction is
//   in flight at a time. The response is routed back to the master that
//   issued the command.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   i_A*            ibus command channel (AVALID/AREADY/AADDR/AEXC)
//   i_B*            ibus response channel (BVALID/BREADY/BDATA/BEXC)
//   d_A*            dbus command channel (adds ADATA/AWMSK for writes)
//   d_B*            dbus response channel
//   s_A*            slave command channel (driven by the current owner)
//   s_B*            slave response channel (routed to the current owner)
//
// Configuration
//   NCPU_SRAM_ARB_DPRIO_EN  when defined, dbus wins every simultaneous
//                           request. When undefined, simultaneous requests
//                           are granted round-robin.
module ncpu32k_sram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // ibus
  input  logic            i_AVALID,
  output logic            i_AREADY,
  input  logic [AW-1:0]   i_AADDR,
  input  logic [1:0]      i_AEXC,
  output logic            i_BVALID,
  input  logic            i_BREADY,
  output logic [IW-1:0]   i_BDATA,
  output logic [1:0]      i_BEXC,
  // dbus
  input  logic            d_AVALID,
  output logic            d_AREADY,
  input  logic [AW-1:0]   d_AADDR,
  input  logic [DW-1:0]   d_ADATA,
  input  logic [DW/8-1:0] d_AWMSK,
  input  logic [1:0]      d_AEXC,
  output logic            d_BVALID,
  input  logic            d_BREADY,
  output logic [IW-1:0]   d_BDATA,
  output logic [1:0]      d_BEXC,
  // slave
  output logic            s_AVALID,
  input  logic            s_AREADY,
  output logic [AW-1:0]   s_AADDR,
  output logic [DW-1:0]   s_ADATA,
  output logic [DW/8-1:0] s_AWMSK,
  output logic [1:0]      s_AEXC,
  input  logic            s_BVALID,
  output logic            s_BREADY,
  input  logic [IW-1:0]   s_BDATA,
  input  logic [1:0]      s_BEXC
);

  typedef enum logic [2:0] {
    IDLE,
    LOCK_I,
    LOCK_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;   // 1: the most recent grant went to dbus
  logic   grant_i, grant_d; // arbitration result, meaningful in IDLE only
  logic   sel_i, sel_d;     // which master currently owns the command path

  // Arbitration. A lone requester always wins. On a tie the round-robin
  // build favours the master that was not granted last time.
  always_comb begin
`ifdef NCPU_SRAM_ARB_DPRIO_EN
    grant_d = d_AVALID;
`else
    grant_d = d_AVALID & (~i_AVALID | ~last);
`endif
    grant_i = i_AVALID & ~grant_d;
  end

  // A LOCK state pins the command path to its owner until the slave accepts,
  // so a late request from the other master cannot steal a pending command.
  assign sel_i = ((state == IDLE) & grant_i) | (state == LOCK_I);
  assign sel_d = ((state == IDLE) & grant_d) | (state == LOCK_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt = s_AREADY ? RESP_I : LOCK_I;
          last_nxt  = 1'b0;
        end else if (grant_d) begin
          state_nxt = s_AREADY ? RESP_D : LOCK_D;
          last_nxt  = 1'b1;
        end
      end
      LOCK_I:  if (i_AVALID & s_AREADY) state_nxt = RESP_I;
      LOCK_D:  if (d_AVALID & s_AREADY) state_nxt = RESP_D;
      RESP_I:  if (s_BVALID & i_BREADY) state_nxt = IDLE;
      RESP_D:  if (s_BVALID & d_BREADY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command and response muxing. Everything is forced to zero while rst is
  // high so the outputs drop in the same instant the reset is asserted,
  // even if a master is still requesting. A slave response outside the
  // RESP states matches no branch and is therefore blocked.
  always_comb begin
    i_AREADY = 1'b0;
    d_AREADY = 1'b0;
    i_BVALID = 1'b0;
    i_BDATA  = '0;
    i_BEXC   = '0;
    d_BVALID = 1'b0;
    d_BDATA  = '0;
    d_BEXC   = '0;
    s_AVALID = 1'b0;
    s_AADDR  = '0;
    s_ADATA  = '0;
    s_AWMSK  = '0;
    s_AEXC   = '0;
    s_BREADY = 1'b0;
    if (!rst) begin
      if (sel_i) begin
        s_AVALID = i_AVALID;
        s_AADDR  = i_AADDR;
        s_AEXC   = i_AEXC;
        i_AREADY = s_AREADY;
      end else if (sel_d) begin
        s_AVALID = d_AVALID;
        s_AADDR  = d_AADDR;
        s_ADATA  = d_ADATA;
        s_AWMSK  = d_AWMSK;
        s_AEXC   = d_AEXC;
        d_AREADY = s_AREADY;
      end
      if (state == RESP_I) begin
        i_BVALID = s_BVALID;
        i_BDATA  = s_BDATA;
        i_BEXC   = s_BEXC;
        s_BREADY = i_BREADY;
      end else if (state == RESP_D) begin
        d_BVALID = s_BVALID;
        d_BDATA  = s_BDATA;
        d_BEXC   = s_BEXC;
        s_BREADY = d_BREADY;
      end
    end
  end

endmodule

// File: tb/tb_ncpu32k_sram_arbiter.sv
// tb_ncpu32k_sram_arbiter
//   Directed bench for ncpu32k_sram_arbiter. The slave side is a small
//   word memory driven from the stimulus sequence. Expected responses are
//   queued when a command is accepted and checked when the owning master
//   completes its response handshake.
module tb_ncpu32k_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        i_AVALID, i_AREADY, i_BVALID, i_BREADY;
  logic [31:0] i_AADDR, i_BDATA;
  logic [1:0]  i_AEXC, i_BEXC;
  logic        d_AVALID, d_AREADY, d_BVALID, d_BREADY;
  logic [31:0] d_AADDR, d_ADATA, d_BDATA;
  logic [3:0]  d_AWMSK;
  logic [1:0]  d_AEXC, d_BEXC;
  logic        s_AVALID, s_AREADY, s_BVALID, s_BREADY;
  logic [31:0] s_AADDR, s_ADATA, s_BDATA;
  logic [3:0]  s_AWMSK;
  logic [1:0]  s_AEXC, s_BEXC;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    logic [1:0]  exc;
  } resp_t;

  resp_t       sb[$];
  resp_t       r;
  logic [31:0] mem [0:255];
  logic [31:0] slv_rdata;
  int          errors = 0;
  int          checks = 0;
  bit          w_d;

  ncpu32k_sram_arbiter #(.AW(32), .DW(32), .IW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_AVALID (i_AVALID),
    .i_AREADY (i_AREADY),
    .i_AADDR  (i_AADDR),
    .i_AEXC   (i_AEXC),
    .i_BVALID (i_BVALID),
    .i_BREADY (i_BREADY),
    .i_BDATA  (i_BDATA),
    .i_BEXC   (i_BEXC),
    .d_AVALID (d_AVALID),
    .d_AREADY (d_AREADY),
    .d_AADDR  (d_AADDR),
    .d_ADATA  (d_ADATA),
    .d_AWMSK  (d_AWMSK),
    .d_AEXC   (d_AEXC),
    .d_BVALID (d_BVALID),
    .d_BREADY (d_BREADY),
    .d_BDATA  (d_BDATA),
    .d_BEXC   (d_BEXC),
    .s_AVALID (s_AVALID),
    .s_AREADY (s_AREADY),
    .s_AADDR  (s_AADDR),
    .s_ADATA  (s_ADATA),
    .s_AWMSK  (s_AWMSK),
    .s_AEXC   (s_AEXC),
    .s_BVALID (s_BVALID),
    .s_BREADY (s_BREADY),
    .s_BDATA  (s_BDATA),
    .s_BEXC   (s_BEXC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit iv, input logic [31:0] ia,
                               input bit dv, input logic [31:0] da,
                               input logic [31:0] dd, input logic [3:0] dm,
                               input bit sar, input bit sbv,
                               input logic [31:0] sbd, input logic [1:0] sbe,
                               input bit ibr, input bit dbr);
    i_AVALID = iv;
    i_AADDR  = ia;
    d_AVALID = dv;
    d_AADDR  = da;
    d_ADATA  = dd;
    d_AWMSK  = dm;
    s_AREADY = sar;
    s_BVALID = sbv;
    s_BDATA  = sbd;
    s_BEXC   = sbe;
    i_BREADY = ibr;
    d_BREADY = dbr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave memory: applies a masked write and latches read data when the
  // command handshake is visible on the slave port.
  task automatic slaveAccept();
    if (s_AVALID && s_AREADY) begin
      for (int b = 0; b < 4; b++)
        if (s_AWMSK[b]) mem[s_AADDR[9:2]][b*8 +: 8] = s_ADATA[b*8 +: 8];
      slv_rdata = mem[s_AADDR[9:2]];
    end
  endtask

  task automatic popResponse(input string tag);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s_sb_empty: observed=0 expected=1", tag);
    end
    if (sb.size() != 0) begin
      r = sb.pop_front();
      checkOutput({tag, "_i_bvalid"}, i_BVALID, {31'b0, !r.is_d});
      checkOutput({tag, "_d_bvalid"}, d_BVALID, {31'b0, r.is_d});
      checkOutput({tag, "_s_bready"}, s_BREADY, 32'd1);
      checkOutput({tag, "_bdata"}, r.is_d ? d_BDATA : i_BDATA, r.data);
      checkOutput({tag, "_bexc"}, r.is_d ? d_BEXC : i_BEXC, {30'b0, r.exc});
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    slv_rdata = 32'h0;
    i_AEXC = 2'b01;
    d_AEXC = 2'b10;
    rst = 1'b1;

    // Reset: outputs stay zero even with active requests and a response.
    applyStimulus(1, 32'h100, 1, 32'h40, 32'h1, 4'hf, 1, 1, 32'h5, 2'b11, 1, 1);
    checkOutput("rst_i_aready", i_AREADY, 0);
    checkOutput("rst_d_aready", d_AREADY, 0);
    checkOutput("rst_i_bvalid", i_BVALID, 0);
    checkOutput("rst_d_bvalid", d_BVALID, 0);
    checkOutput("rst_s_avalid", s_AVALID, 0);
    checkOutput("rst_s_bready", s_BREADY, 0);
    checkOutput("rst_s_aaddr", s_AADDR, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();

    // Simultaneous requests held for four transactions.
    for (int t = 0; t < 4; t++) begin
`ifdef NCPU_SRAM_ARB_DPRIO_EN
      w_d = 1'b1;
`else
      w_d = (t % 2 == 0);
`endif
      applyStimulus(1, 32'h1000 + t*4, 1, 32'h2000 + t*4, 32'h0, 4'h0,
                    1, 0, 0, 0, 1, 1);
      checkOutput("rr_s_aaddr", s_AADDR, w_d ? 32'h2000 + t*4 : 32'h1000 + t*4);
      checkOutput("rr_i_aready", i_AREADY, {31'b0, !w_d});
      checkOutput("rr_d_aready", d_AREADY, {31'b0, w_d});
      sb.push_back('{w_d, 32'hA000_0000 + t, 2'b00});
      tick();
      applyStimulus(1, 32'h1000 + t*4, 1, 32'h2000 + t*4, 32'h0, 4'h0,
                    1, 1, 32'hA000_0000 + t, 2'b00, 1, 1);
      checkOutput("rr_hold_i_aready", i_AREADY, 0);
      checkOutput("rr_hold_d_aready", d_AREADY, 0);
      checkOutput("rr_hold_s_avalid", s_AVALID, 0);
      popResponse("rr");
      tick();
    end

    // Lock: slave stalls the ibus command while dbus starts requesting.
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lock_s_avalid", s_AVALID, 1);
    checkOutput("lock_s_aaddr0", s_AADDR, 32'h300);
    checkOutput("lock_i_aready0", i_AREADY, 0);
    tick();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1, 32'h300, 1, 32'h40, 32'h1234_5678, 4'b0011,
                    0, 0, 0, 0, 0, 0);
      checkOutput("lock_s_aaddr", s_AADDR, 32'h300);
      checkOutput("lock_s_aexc", s_AEXC, 32'h1);
      checkOutput("lock_d_aready", d_AREADY, 0);
      tick();
    end
    applyStimulus(1, 32'h300, 1, 32'h40, 32'h1234_5678, 4'b0011,
                  1, 0, 0, 0, 0, 0);
    checkOutput("lock_acc_i_aready", i_AREADY, 1);
    checkOutput("lock_acc_d_aready", d_AREADY, 0);
    checkOutput("lock_acc_s_aaddr", s_AADDR, 32'h300);
    slaveAccept();
    sb.push_back('{1'b0, 32'h3333_3333, 2'b11});
    tick();

    // Back-pressure: owner holds BREADY low for five cycles.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 1, 32'h40, 32'h1234_5678, 4'b0011,
                    1, 1, 32'h3333_3333, 2'b11, 0, 1);
      checkOutput("bp_s_bready", s_BREADY, 0);
      checkOutput("bp_i_bvalid", i_BVALID, 1);
      checkOutput("bp_d_bvalid", d_BVALID, 0);
      checkOutput("bp_d_aready", d_AREADY, 0);
      tick();
    end
    applyStimulus(0, 0, 1, 32'h40, 32'h1234_5678, 4'b0011,
                  1, 1, 32'h3333_3333, 2'b11, 1, 1);
    checkOutput("bp_end_d_aready", d_AREADY, 0);
    popResponse("bp");
    tick();

    // Dbus write, granted the cycle after the ibus response.
    applyStimulus(0, 0, 1, 32'h40, 32'h1234_5678, 4'b0011, 1, 0, 0, 0, 0, 0);
    checkOutput("wr_d_aready", d_AREADY, 1);
    checkOutput("wr_i_aready", i_AREADY, 0);
    checkOutput("wr_s_aaddr", s_AADDR, 32'h40);
    checkOutput("wr_s_adata", s_ADATA, 32'h1234_5678);
    checkOutput("wr_s_awmsk", s_AWMSK, 32'h3);
    checkOutput("wr_s_aexc", s_AEXC, 32'h2);
    slaveAccept();
    sb.push_back('{1'b1, 32'h0, 2'b00});
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 2'b00, 1, 1);
    popResponse("wr");
    tick();

    // Single ibus fetch.
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("if_s_aaddr", s_AADDR, 32'h100);
    checkOutput("if_s_awmsk", s_AWMSK, 0);
    checkOutput("if_s_adata", s_ADATA, 0);
    checkOutput("if_i_aready", i_AREADY, 1);
    slaveAccept();
    sb.push_back('{1'b0, 32'hDEAD_BEEF, 2'b00});
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 2'b00, 1, 1);
    popResponse("if");
    tick();

    // A stray slave response in IDLE is blocked.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'hBAD0_0000, 2'b01, 1, 1);
    checkOutput("stray_i_bvalid", i_BVALID, 0);
    checkOutput("stray_d_bvalid", d_BVALID, 0);
    checkOutput("stray_s_bready", s_BREADY, 0);
    checkOutput("stray_s_avalid", s_AVALID, 0);

    // Dbus read back of the half-written word.
    applyStimulus(0, 0, 1, 32'h40, 32'h0, 4'h0, 1, 0, 0, 0, 0, 0);
    checkOutput("rd_d_aready", d_AREADY, 1);
    slaveAccept();
    sb.push_back('{1'b1, 32'h0000_5678, 2'b00});
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, slv_rdata, 2'b00, 1, 1);
    popResponse("rd");
    tick();

    // Reset asserted while a dbus response is pending.
    applyStimulus(0, 0, 1, 32'h80, 32'h0, 4'h0, 1, 0, 0, 0, 0, 0);
    checkOutput("mr_d_aready", d_AREADY, 1);
    tick();
    applyStimulus(1, 32'h500, 1, 32'h80, 32'h0, 4'h0, 1, 1, 32'hCAFE_F00D, 2'b10, 1, 1);
    checkOutput("mr_pre_d_bvalid", d_BVALID, 1);
    rst = 1'b1;
    #1;
    checkOutput("mr_i_aready", i_AREADY, 0);
    checkOutput("mr_d_aready0", d_AREADY, 0);
    checkOutput("mr_i_bvalid", i_BVALID, 0);
    checkOutput("mr_d_bvalid", d_BVALID, 0);
    checkOutput("mr_d_bdata", d_BDATA, 0);
    checkOutput("mr_s_avalid", s_AVALID, 0);
    checkOutput("mr_s_bready", s_BREADY, 0);
    checkOutput("mr_s_aaddr", s_AADDR, 0);
    tick();
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_i_aready", i_AREADY, 1);
    checkOutput("post_s_aaddr", s_AADDR, 32'h500);
    slaveAccept();
    sb.push_back('{1'b0, 32'h5555_AAAA, 2'b01});
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h5555_AAAA, 2'b01, 1, 1);
    popResponse("post");
    tick();

    checkOutput("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ncpu32k_sram_arbiter.md
# ncpu32k_sram_arbiter

Two-master to one-slave arbiter for the ncpu32k command/response handshake bus. It lets the instruction bus (fb_ibus_*) and the data bus (fb_dbus_*) of one ncpu32k core share a single handshake_cmd_sram. Systems built with it need one memory model or controller instead of two. The arbiter allows one transaction at a time and routes each response back to the master that issued the command.

## Interface
- AW, 32, address width (`NCPU_AW)
- DW, 32, data-bus write data width (`NCPU_DW)
- IW, 32, response data width (`NCPU_IW)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- i_AVALID/i_AREADY  input/output  1/1  ibus command handshake
- i_AADDR  input  AW  ibus address
- i_AEXC  input  2  ibus command exception tag
- i_BVALID/i_BREADY  output/input  1/1  ibus response handshake
- i_BDATA  output  IW  ibus response data
- i_BEXC  output  2  ibus response exception
- d_AVALID/d_AREADY  input/output  1/1  dbus command handshake
- d_AADDR  input  AW  dbus address
- d_ADATA  input  DW  dbus write data
- d_AWMSK  input  DW/8  dbus byte write mask
- d_AEXC  input  2  dbus command exception tag
- d_BVALID/d_BREADY  output/input  1/1  dbus response handshake
- d_BDATA  output  IW  dbus response data
- d_BEXC  output  2  dbus response exception
- s_AVALID/s_AREADY  output/input  1/1  slave command handshake
- s_AADDR, s_ADATA, s_AWMSK, s_AEXC  output  AW/DW/DW/8/2  slave command fields
- s_BVALID/s_BREADY  input/output  1/1  slave response handshake
- s_BDATA, s_BEXC  input  IW/2  slave response fields

## Operation
- States: IDLE, LOCK_I, LOCK_D, RESP_I, RESP_D. Reset state is IDLE.
- Register `last`: 1 means the last grant went to dbus. Reset value is 0.
- Arbitration happens only in IDLE.
  - Only one of i_AVALID/d_AVALID high: that master wins.
  - Both high: the master not named by `last` wins (round-robin).
- Winner's command is forwarded combinationally to s_A*, and s_AREADY is forwarded to the winner's AREADY.
  - ibus drives s_ADATA=0 and s_AWMSK=0.
  - The loser's AREADY is 0.
- IDLE with the winner's s_AVALID&s_AREADY: go to RESP_x and update `last`.
- IDLE with s_AVALID=1 but s_AREADY=0: go to LOCK_x.
  - LOCK_x keeps the grant fixed until the command is accepted, even if the other master asserts AVALID.
  - When the command is accepted, go to RESP_x.
- RESP_x:
  - s_B* is routed to the owner; s_BREADY = owner's BREADY.
  - The non-owner's BVALID is 0.
  - All AREADY outputs are 0 and s_AVALID is 0.
  - On s_BVALID&s_BREADY, go to IDLE.
- A master must hold AVALID and its fields stable until AREADY. A violation is undefined.
- The slave must not assert s_BVALID in IDLE or LOCK_x. Such a response is blocked: s_BREADY=0 and both BVALID=0.

## Timing
- Command path from master to slave is zero-latency combinational. AREADY is combinational from s_AREADY and the grant.
- Response path from slave to owner is zero-latency combinational.
- After a response handshake in cycle N, the earliest next command acceptance is cycle N+1.
- Reset values of all outputs: i_AREADY=d_AREADY=0, i_BVALID=d_BVALID=0, s_AVALID=0, s_BREADY=0, and all data/exception outputs 0.
- Asserting rst mid-transaction forces IDLE immediately.
  - The pending response is discarded.
  - The slave must be reset together with the arbiter.
- AVALID arriving during RESP_x is held off (AREADY=0). It is arbitrated in the cycle the FSM is back in IDLE.

## Configuration
- Macro NCPU_SRAM_ARB_DPRIO_EN.
- Defined: dbus has fixed priority. On simultaneous requests in IDLE, dbus always wins and `last` is ignored.
- Undefined: round-robin as described above.
- LOCK_x behaviour is identical in both builds.

## Test plan
- **Single ibus fetch.** i_AVALID=1 at AADDR=0x100 with slave AREADY=1 → s_AADDR=0x100 same cycle, s_AWMSK=0. Slave BDATA=0xDEADBEEF → i_BVALID=1, i_BDATA=0xDEADBEEF, d_BVALID=0.
- **Simultaneous requests, round-robin.** Both AVALID held high for 4 transactions, `last`=0 after reset → grant order d, i, d, i. With NCPU_SRAM_ARB_DPRIO_EN → the dbus command is serviced first (d before the pending i).
- **Lock.** Slave AREADY=0 for 3 cycles while ibus is granted, and d_AVALID rises in cycle 1 → grant stays ibus. d_AREADY stays 0 until the ibus response completes.
- **Dbus write.** d_ADATA=0x12345678, d_AWMSK=4'b0011, AADDR=0x40 → slave sees identical fields. The response goes to dbus only, and a following read of 0x40 returns low halfword 0x5678.
- **Back-pressure.** Owner BREADY=0 for 5 cycles while s_BVALID=1 → s_BREADY=0 and the FSM stays in RESP. It returns to IDLE the cycle after BREADY=1.
- **Mid-transaction reset.** rst asserted while in RESP_D → all outputs 0 immediately and state IDLE. After deassertion a new ibus request is granted first (`last`=0).
